// File: rtl/key_matrix_scanner_pkg.sv
// Shared definitions for the key matrix scanner: matrix geometry, event
// record layout and the key index helper.
package key_matrix_scanner_pkg;

   localparam int ROWS = 8;
   localparam int COLS = 8;
   localparam int KEYS = ROWS * COLS;

   // Event record layout: {press, row[2:0], col[2:0]}
   localparam int EVT_W         = 7;
   localparam int EVT_PRESS_BIT = 6;
   localparam int EVT_ROW_MSB   = 5;
   localparam int EVT_ROW_LSB   = 3;
   localparam int EVT_COL_MSB   = 2;
   localparam int EVT_COL_LSB   = 0;

   typedef struct packed {
      logic       press;
      logic [2:0] row;
      logic [2:0] col;
   } kbd_evt_t;

   // Bit position of key (row, col) in the 64-bit key map: row*8+col
   function automatic logic [5:0] key_index(input logic [2:0] row, input logic [2:0] col);
      return {row, col};
   endfunction

endpackage

// File: rtl/key_matrix_scanner_event_fifo.sv
// kbd_event_fifo: small register FIFO with valid/ready pop. A push into a
// full FIFO is only accepted when a pop happens in the same cycle;
// otherwise it is dropped and flagged on drop. DEPTH is a power of 2, >= 2.
module kbd_event_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop_ready,
   output logic             valid,
   output logic [WIDTH-1:0] head,
   output logic             full,
   output logic             empty,
   output logic             drop
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic             pop;
   logic             push_ok;

   // Extra pointer bit separates the full and empty cases
   assign empty   = (wr_ptr_q == rd_ptr_q);
   assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign valid   = !empty;
   assign head    = mem_q[rd_ptr_q[AW-1:0]];
   assign pop     = valid && pop_ready;
   assign push_ok = push && (!full || pop);
   assign drop    = push && full && !pop;

   // Next-state for storage and pointers
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) begin
         mem_d[wr_ptr_q[AW-1:0]] = push_data;
         wr_ptr_d                = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   // State registers; reset empties the queue and zeroes the head fields
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

endmodule

// File: rtl/key_matrix_scanner.sv
// key_matrix_scanner: strobes one row low per slot, samples the columns at
// the end of the slot, then walks that row's 8 keys one per cycle through
// per-key debounce counters, updating the key map and queueing events.
module key_matrix_scanner
   import key_matrix_scanner_pkg::*;
#(
   parameter int SCAN_DIV_W = 13,
   parameter int DEBOUNCE   = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic [7:0]  row_n,
   input  logic [7:0]  col_n,
   output logic [63:0] key_state,
   output logic        evt_valid,
   input  logic        evt_ready,
   output logic        evt_press,
   output logic [2:0]  evt_row,
   output logic [2:0]  evt_col,
   output logic        ovf
);
   localparam int CNT_W = $clog2(DEBOUNCE);
   localparam logic [SCAN_DIV_W-1:0] P_MAX    = '1;
   localparam logic [SCAN_DIV_W-1:0] P_ONE    = SCAN_DIV_W'(1);
   localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DEBOUNCE - 1);
   localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);

   logic [7:0]            col_meta_q, col_meta_d;
   logic [7:0]            col_sync_q, col_sync_d;
   logic [SCAN_DIV_W-1:0] p_q, p_d;
   logic [2:0]            r_q, r_d;
   logic [7:0]            samp_q, samp_d;
   logic [2:0]            wrow_q, wrow_d;
   logic [63:0]           key_state_q, key_state_d;
   logic [CNT_W-1:0]      cnt_q [KEYS];
   logic [CNT_W-1:0]      cnt_d [KEYS];
   logic                  ovf_q, ovf_d;

   logic                  walk_en;
   logic [2:0]            walk_col;
   logic [5:0]            walk_idx;
   logic                  walk_samp;
   logic                  push_en;
   kbd_evt_t              push_evt;
   logic [EVT_W-1:0]      fifo_head;
   logic                  fifo_full, fifo_empty, fifo_drop;
   logic                  unused_fifo_flags;

   // Walk runs in the first 8 cycles of the slot after the sample
   assign walk_en   = (p_q[SCAN_DIV_W-1:3] == '0);
   assign walk_col  = p_q[2:0];
   assign walk_idx  = key_index(wrow_q, walk_col);
   assign walk_samp = samp_q[walk_col];

   // Synchronizer, prescaler, row counter and end-of-slot column capture
   always_comb begin
      col_meta_d = col_n;
      col_sync_d = col_meta_q;
      p_d        = p_q + P_ONE;
      r_d        = r_q;
      samp_d     = samp_q;
      wrow_d     = wrow_q;
      if (p_q == P_MAX) begin
         r_d    = r_q + 3'd1;
         samp_d = ~col_sync_q;
         wrow_d = r_q;
      end
   end

   // Debounce one key per walk cycle; flip and push on the last agreeing count
   always_comb begin
      cnt_d          = cnt_q;
      key_state_d    = key_state_q;
      push_en        = 1'b0;
      push_evt.press = walk_samp;
      push_evt.row   = wrow_q;
      push_evt.col   = walk_col;
      if (walk_en) begin
         if (walk_samp == key_state_q[walk_idx]) begin
            cnt_d[walk_idx] = '0;
         end else if (cnt_q[walk_idx] != CNT_LAST) begin
            cnt_d[walk_idx] = cnt_q[walk_idx] + CNT_ONE;
         end else begin
            key_state_d[walk_idx] = walk_samp;
            cnt_d[walk_idx]       = '0;
            push_en               = 1'b1;
         end
      end
   end

   // Overflow is sticky until reset
   always_comb begin
      ovf_d = ovf_q | fifo_drop;
   end

   // All scanner state; reset releases every key and restarts at row 0
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         col_meta_q  <= 8'hFF;
         col_sync_q  <= 8'hFF;
         p_q         <= '0;
         r_q         <= '0;
         samp_q      <= '0;
         wrow_q      <= '0;
         key_state_q <= '0;
         for (int i = 0; i < KEYS; i++) cnt_q[i] <= '0;
         ovf_q       <= 1'b0;
      end else begin
         col_meta_q  <= col_meta_d;
         col_sync_q  <= col_sync_d;
         p_q         <= p_d;
         r_q         <= r_d;
         samp_q      <= samp_d;
         wrow_q      <= wrow_d;
         key_state_q <= key_state_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
      end
   end

   kbd_event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (EVT_W)
   ) u_event_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push_en),
      .push_data (push_evt),
      .pop_ready (evt_ready),
      .valid     (evt_valid),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .drop      (fifo_drop)
   );

   // Flow control is handled inside the FIFO; these flags are not needed here
   assign unused_fifo_flags = fifo_full | fifo_empty;

   assign row_n     = ~(8'h01 << r_q);
   assign key_state = key_state_q;
   assign evt_press = fifo_head[EVT_PRESS_BIT];
   assign evt_row   = fifo_head[EVT_ROW_MSB:EVT_ROW_LSB];
   assign evt_col   = fifo_head[EVT_COL_MSB:EVT_COL_LSB];
   assign ovf       = ovf_q;

endmodule
